// File: rtl/axi_bram_reader.sv
// AXI4-Lite read-only window onto BRAM port A.
// Writes are terminated with SLVERR; one read in flight.
module axi_bram_reader #(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 16,
  parameter int BRAM_DATA_WIDTH   = 32,
  parameter int BRAM_ADDR_WIDTH   = 10,
  parameter int BRAM_READ_LATENCY = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic                         bram_porta_en,
  input  logic [BRAM_DATA_WIDTH-1:0]   bram_porta_rddata
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    EN,
    WAIT,
    RESP
  } state_t;

  state_t                       state;
  state_t                       state_nx;
  logic [1:0]                   cnt;
  logic [1:0]                   cnt_nx;
  logic                         load;
  logic                         ar_hs;
  logic                         aw_hs;
  logic                         bvalid;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]    rdata_q;
  logic                         unused_ok;

  assign ar_hs = s_axi_arvalid & s_axi_arready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ar_hs) state_nx = EN;
      end
      EN: begin
        state_nx = WAIT;
        cnt_nx   = 2'(BRAM_READ_LATENCY - 1);
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          state_nx = RESP;
          load     = 1'b1;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      RESP: begin
        if (s_axi_rready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ar_hs) addr_q <= s_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
      if (load) rdata_q <= bram_porta_rddata;
    end
  end

  assign s_axi_arready   = (state == IDLE);
  assign s_axi_rvalid    = (state == RESP);
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = 2'b00;
  assign bram_porta_en   = (state == EN);
  assign bram_porta_addr = addr_q;
  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;

  // Write path: accept AW and W together, answer SLVERR.
  assign aw_hs         = s_axi_awvalid & s_axi_wvalid & ~bvalid;
  assign s_axi_awready = aw_hs;
  assign s_axi_wready  = aw_hs;
  assign s_axi_bvalid  = bvalid;
  assign s_axi_bresp   = 2'b10;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bvalid <= 1'b0;
    end else if (aw_hs) begin
      bvalid <= 1'b1;
    end else if (bvalid & s_axi_bready) begin
      bvalid <= 1'b0;
    end
  end

  assign unused_ok = ^{s_axi_awaddr, s_axi_wdata, s_axi_wstrb,
                       s_axi_araddr};

endmodule

// File: tb/tb_axi_bram_reader.sv
// Bench for axi_bram_reader: latency-1 and latency-3
// instances with BRAM models and an R-data scoreboard.
module tb_axi_bram_reader;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [1:0]  bram_en, bram_clk, bram_rst;
  logic [15:0] awaddr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2];
  logic [1:0]  rresp [2];
  logic [15:0] araddr [2];
  logic [31:0] rdata [2];
  logic [31:0] rddata [2];
  logic [9:0]  bram_addr [2];

  axi_bram_reader #(.BRAM_READ_LATENCY(1)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr[0]), .s_axi_awvalid(awvalid[0]),
    .s_axi_awready(awready[0]), .s_axi_wdata(wdata[0]),
    .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]),
    .s_axi_wready(wready[0]), .s_axi_bresp(bresp[0]),
    .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
    .s_axi_araddr(araddr[0]), .s_axi_arvalid(arvalid[0]),
    .s_axi_arready(arready[0]), .s_axi_rdata(rdata[0]),
    .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]),
    .s_axi_rready(rready[0]), .bram_porta_clk(bram_clk[0]),
    .bram_porta_rst(bram_rst[0]), .bram_porta_addr(bram_addr[0]),
    .bram_porta_en(bram_en[0]), .bram_porta_rddata(rddata[0])
  );

  axi_bram_reader #(.BRAM_READ_LATENCY(3)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr[1]), .s_axi_awvalid(awvalid[1]),
    .s_axi_awready(awready[1]), .s_axi_wdata(wdata[1]),
    .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]),
    .s_axi_wready(wready[1]), .s_axi_bresp(bresp[1]),
    .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
    .s_axi_araddr(araddr[1]), .s_axi_arvalid(arvalid[1]),
    .s_axi_arready(arready[1]), .s_axi_rdata(rdata[1]),
    .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]),
    .s_axi_rready(rready[1]), .bram_porta_clk(bram_clk[1]),
    .bram_porta_rst(bram_rst[1]), .bram_porta_addr(bram_addr[1]),
    .bram_porta_en(bram_en[1]), .bram_porta_rddata(rddata[1])
  );

  // BRAM models: one output register, or a 3-deep pipeline.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] q0, p1, p2, p3;
  logic        garble = 1'b0;

  always @(posedge aclk) if (bram_en[0]) q0 <= mem0[bram_addr[0]];

  always @(posedge aclk) begin
    if (bram_en[1]) p1 <= mem1[bram_addr[1]];
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    rddata[0] = garble ? 32'hBAD0BAD0 : q0;
    rddata[1] = garble ? 32'hBAD0BAD0 : p3;
  end

  int cyc = 0;
  int en_cnt [2] = '{0, 0};
  int beats [2] = '{0, 0};
  int aw_cnt = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  always begin
    @(negedge aclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (bram_en[k]) en_cnt[k]++;
      if (rvalid[k] && rready[k]) beats[k]++;
    end
    if (awready[0] && wready[0]) aw_cnt++;
  end

  int passed = 0;
  int total = 0;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_read(input int d, input logic [15:0] a,
                         input logic [31:0] ed, input logic [9:0] ew,
                         input int el, input int hold,
                         output int hs_cyc);
    int n, lat, e0, b0;
    logic [31:0] exp;
    logic stable;
    e0 = en_cnt[d];
    b0 = beats[d];
    @(negedge aclk);
    araddr[d]  = a;
    arvalid[d] = 1'b1;
    rready[d]  = (hold == 0);
    n = 0;
    while (!arready[d] && n < 40) begin
      @(negedge aclk);
      n++;
    end
    chk("ar_accept", n < 40, 1);
    @(posedge aclk);
    #1;
    hs_cyc = cyc;
    arvalid[d] = 1'b0;
    if (d == 0) sb0.push_back(ed);
    else sb1.push_back(ed);
    chk("en_addr", {bram_en[d], bram_addr[d]}, {1'b1, ew});
    lat = 0;
    while (!rvalid[d] && lat < 20) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    chk("latency", lat, el);
    chk("en_pulses", en_cnt[d] - e0, 1);
    exp = 32'hx;
    if (d == 0 && sb0.size() > 0) exp = sb0.pop_front();
    if (d == 1 && sb1.size() > 0) exp = sb1.pop_front();
    chk("rdata", rdata[d], exp);
    chk("rresp", rresp[d], 0);
    if (hold > 0) begin
      garble = 1'b1;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge aclk);
        stable &= rvalid[d] & ~arready[d] & (rdata[d] == exp);
      end
      chk("bp_hold", stable, 1);
      garble = 1'b0;
      @(negedge aclk);
      rready[d] = 1'b1;
    end
    @(posedge aclk);
    #1;
    chk("r_done", {rvalid[d], arready[d]}, 2'b01);
    rready[d] = 1'b0;
    chk("beats", beats[d] - b0, 1);
  endtask

  typedef struct {
    int          d;
    logic [15:0] addr;
    logic [31:0] data;
    logic [9:0]  word;
    int          lat;
  } vec_t;

  vec_t vec [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, a0, e0, b0;
    vec[0] = '{0, 16'h0014, 32'hDEADBEEF, 10'd5, 2};
    vec[1] = '{0, 16'h1014, 32'hDEADBEEF, 10'd5, 2};
    vec[2] = '{0, 16'h0000, 32'h11111111, 10'd0, 2};
    vec[3] = '{0, 16'h0FFF, 32'hCAFEF00D, 10'd1023, 2};
    vec[4] = '{1, 16'h0FFC, 32'h12345678, 10'd1023, 4};
    vec[5] = '{1, 16'h0014, 32'hA5A55A5A, 10'd5, 4};
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem0[5]    = 32'hDEADBEEF;
    mem0[0]    = 32'h11111111;
    mem0[1023] = 32'hCAFEF00D;
    mem1[1023] = 32'h12345678;
    mem1[5]    = 32'hA5A55A5A;
    for (int k = 0; k < 2; k++) begin
      awaddr[k] = '0;
      wdata[k]  = '0;
      wstrb[k]  = '0;
      araddr[k] = '0;
    end
    awvalid = '0;
    wvalid  = '0;
    bready  = '0;
    arvalid = '0;
    rready  = '0;

    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_bram_rst", bram_rst, 2'b11);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ctrl", {arready[k], rvalid[k], bram_en[k],
                       bvalid[k], awready[k]}, 5'b10000);
      chk("rst_rdata", rdata[k], 0);
      chk("rst_addr", bram_addr[k], 0);
    end
    aresetn = 1'b1;

    for (int i = 0; i < 6; i++)
      do_read(vec[i].d, vec[i].addr, vec[i].data, vec[i].word,
              vec[i].lat, 0, h1);

    do_read(0, 16'h0014, 32'hDEADBEEF, 10'd5, 2, 10, h1);

    do_read(1, 16'h0FFC, 32'h12345678, 10'd1023, 4, 0, h1);
    do_read(1, 16'h0FFC, 32'h12345678, 10'd1023, 4, 0, h2);
    chk("period_l3", h2 - h1, 6);
    do_read(0, 16'h0000, 32'h11111111, 10'd0, 2, 0, h1);
    do_read(0, 16'h0014, 32'hDEADBEEF, 10'd5, 2, 0, h2);
    chk("period_l1", h2 - h1, 4);

    a0 = aw_cnt;
    e0 = en_cnt[0];
    @(negedge aclk);
    awvalid[0] = 1'b1;
    wvalid[0]  = 1'b1;
    bready[0]  = 1'b0;
    #1;
    chk("aw_comb", {awready[0], wready[0]}, 2'b11);
    repeat (3) @(negedge aclk);
    chk("b_hold", {bvalid[0], bresp[0]}, {1'b1, 2'b10});
    chk("aw_once", aw_cnt - a0, 1);
    bready[0] = 1'b1;
    #1;
    chk("aw_blocked", awready[0], 0);
    @(posedge aclk);
    #1;
    chk("aw_reaccept", {bvalid[0], awready[0]}, 2'b01);
    @(posedge aclk);
    #1;
    awvalid[0] = 1'b0;
    wvalid[0]  = 1'b0;
    chk("b_again", bvalid[0], 1);
    @(posedge aclk);
    #1;
    chk("b_clear", bvalid[0], 0);
    bready[0] = 1'b0;
    chk("aw_twice", aw_cnt - a0, 2);
    chk("w_no_en", en_cnt[0] - e0, 0);

    b0 = beats[1];
    @(negedge aclk);
    araddr[1]  = 16'h0014;
    arvalid[1] = 1'b1;
    rready[1]  = 1'b1;
    @(posedge aclk);
    #1;
    arvalid[1] = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("rst_wait", {rvalid[1], arready[1], bram_en[1]}, 3'b010);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (6) @(negedge aclk);
    chk("rst_no_beat", beats[1] - b0, 0);
    rready[1] = 1'b0;
    do_read(1, 16'h0014, 32'hA5A55A5A, 10'd5, 4, 0, h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
